// File: rtl/fir_datapath.sv
// FIR execution stage: 16-entry register file plus a single-cycle ALU driven by the controller.
// Optional macro SATURATE_EN clamps ADD/SUB/MUL results on overflow instead of wrapping.
module fir_datapath #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [3:0]        src1,
    input  logic [3:0]        src2,
    input  logic [3:0]        dest,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] fir_coeff,
    output logic [DATA_W-1:0] outreg_data,
    output logic              overflow
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_COPY   = 3'b001,
        OP_LOAD_S = 3'b010,
        OP_LOAD_C = 3'b011,
        OP_ADD    = 3'b100,
        OP_SUB    = 3'b101,
        OP_MUL    = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    logic [DATA_W-1:0]          regs_q [NREG];
    logic [DATA_W-1:0]          regs_d [NREG];

    logic signed [DATA_W-1:0]   a;
    logic signed [DATA_W-1:0]   b;
    logic signed [DATA_W-1:0]   sum;
    logic signed [DATA_W-1:0]   diff;
    logic signed [2*DATA_W-1:0] prod;
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic                       ovf;

`ifdef SATURATE_EN
    localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
    logic res_neg;
`endif

    // NOTE: every signal driven here gets a default before the case, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        a       = regs_q[src1];
        b       = regs_q[src2];
        sum     = a + b;
        diff    = a - b;
        prod    = a * b;
        wr_en   = 1'b0;
        wr_data = '0;
        ovf     = 1'b0;

        unique case (op_e'(op))
            OP_COPY: begin
                wr_en   = 1'b1;
                wr_data = a;
            end
            OP_LOAD_S: begin
                wr_en   = 1'b1;
                wr_data = sample_data;
            end
            OP_LOAD_C: begin
                wr_en   = 1'b1;
                wr_data = fir_coeff;
            end
            OP_ADD: begin
                wr_en   = 1'b1;
                wr_data = sum;
                ovf     = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                wr_en   = 1'b1;
                wr_data = diff;
                ovf     = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_MUL: begin
                wr_en   = 1'b1;
                wr_data = prod[DATA_W-1:0];
                // In range only if the upper half is a pure sign extension of the low word.
                ovf     = prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[DATA_W-1]}};
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase

`ifdef SATURATE_EN
        // On ADD/SUB overflow the true result carries the sign of a; MUL keeps its exact sign.
        res_neg = (op_e'(op) == OP_MUL) ? prod[2*DATA_W-1] : a[DATA_W-1];
        if (ovf) begin
            wr_data = res_neg ? MIN_VAL : MAX_VAL;
        end
`endif

        regs_d = regs_q;
        if (wr_en) begin
            regs_d[dest] = wr_data;
        end
    end

    // NOTE: the register file is reset on purpose: a controller reset must also
    // discard loaded coefficients, so this memory is built from resettable flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignment so all reads in this
            // cycle see the pre-edge register contents (no write-through bypass).
            regs_q <= regs_d;
        end
    end

    assign outreg_data = regs_q[0];
    assign overflow    = ovf;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed self-checking bench for fir_datapath; registers are observed by copying them into r0.
// Expected values follow the SATURATE_EN setting of the build.
module tb_fir_datapath;

    localparam logic [2:0] NOP    = 3'b000;
    localparam logic [2:0] COPY   = 3'b001;
    localparam logic [2:0] LOAD_S = 3'b010;
    localparam logic [2:0] LOAD_C = 3'b011;
    localparam logic [2:0] ADD    = 3'b100;
    localparam logic [2:0] SUB    = 3'b101;
    localparam logic [2:0] MUL    = 3'b110;
    localparam logic [2:0] RSVD   = 3'b111;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [3:0]  src1, src2, dest;
    logic [15:0] sample_data, fir_coeff;
    logic [15:0] outreg_data;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  ra;
        logic [15:0] a;
        logic [3:0]  rb;
        logic [15:0] b;
        logic [3:0]  rd;
        logic        ovf;
        logic [15:0] wrap;
        logic [15:0] sat;
    } vec_t;

    vec_t vecs [12];

    fir_datapath #(.DATA_W(16), .NREG(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .dest        (dest),
        .sample_data (sample_data),
        .fir_coeff   (fir_coeff),
        .outreg_data (outreg_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one op mid-cycle; returns 1 time unit later so combinational outputs have settled.
    task automatic issue(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic [15:0] sd, input logic [15:0] fc);
        @(negedge clk);
        op = o; src1 = s1; src2 = s2; dest = d; sample_data = sd; fir_coeff = fc;
        #1;
    endtask

    task automatic load(input logic [3:0] r, input logic [15:0] v);
        issue(LOAD_S, 4'd0, 4'd0, r, v, 16'h0);
    endtask

    task automatic read_reg(input logic [3:0] r, input string tag, input logic [15:0] exp);
        issue(COPY, r, 4'd0, 4'd0, 16'h0, 16'h0);
        issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        check(tag, outreg_data, exp);
    endtask

    initial begin
        vecs[0]  = '{ADD, 4'd2, 16'h7FFF, 4'd3, 16'h0001, 4'd4, 1'b1, 16'h8000, 16'h7FFF};
        vecs[1]  = '{SUB, 4'd2, 16'h8000, 4'd3, 16'h0001, 4'd4, 1'b1, 16'h7FFF, 16'h8000};
        vecs[2]  = '{MUL, 4'd1, 16'h0100, 4'd6, 16'h0100, 4'd9, 1'b1, 16'h0000, 16'h7FFF};
        vecs[3]  = '{ADD, 4'd2, 16'h8000, 4'd3, 16'hFFFF, 4'd4, 1'b1, 16'h7FFF, 16'h8000};
        vecs[4]  = '{ADD, 4'd2, 16'h1234, 4'd3, 16'h0101, 4'd0, 1'b0, 16'h1335, 16'h1335};
        vecs[5]  = '{SUB, 4'd2, 16'h0005, 4'd3, 16'h0007, 4'd0, 1'b0, 16'hFFFE, 16'hFFFE};
        vecs[6]  = '{SUB, 4'd2, 16'h7FFF, 4'd3, 16'hFFFF, 4'd7, 1'b1, 16'h8000, 16'h7FFF};
        vecs[7]  = '{MUL, 4'd2, 16'hFFFE, 4'd3, 16'h0003, 4'd0, 1'b0, 16'hFFFA, 16'hFFFA};
        vecs[8]  = '{MUL, 4'd2, 16'h8000, 4'd3, 16'h8000, 4'd0, 1'b1, 16'h0000, 16'h7FFF};
        vecs[9]  = '{MUL, 4'd2, 16'hFFFF, 4'd3, 16'h8000, 4'd0, 1'b1, 16'h8000, 16'h7FFF};
        vecs[10] = '{MUL, 4'd2, 16'h8000, 4'd3, 16'h0001, 4'd0, 1'b0, 16'h8000, 16'h8000};
        vecs[11] = '{MUL, 4'd2, 16'h8000, 4'd3, 16'h0002, 4'd0, 1'b1, 16'h0000, 16'h8000};

        op = NOP; src1 = '0; src2 = '0; dest = '0; sample_data = '0; fir_coeff = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("por_outreg", outreg_data, 16'h0);
        check("por_ovf", overflow, 1'b0);
        rst = 1'b0;

        // Mid-run reset: populate registers, then reset between clock edges.
        load(4'd0, 16'h1234);
        load(4'd5, 16'hBEEF);
        issue(LOAD_C, 4'd0, 4'd0, 4'd11, 16'h0, 16'h0003);
        issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("pre_rst_r0", outreg_data, 16'h1234);
        #1 rst = 1'b1;
        #1 check("async_rst_r0", outreg_data, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            read_reg(r[3:0], $sformatf("rst_r%0d", r), 16'h0);
        end
        check("rst_ovf", overflow, 1'b0);

        // Coefficient x sample into the accumulator.
        issue(LOAD_C, 4'd0, 4'd0, 4'd5, 16'hFFFF, 16'h0003);
        check("loadc_ovf", overflow, 1'b0);
        issue(LOAD_S, 4'd0, 4'd0, 4'd1, 16'h0010, 16'hFFFF);
        check("loads_ovf", overflow, 1'b0);
        issue(MUL, 4'd1, 4'd5, 4'd0, 16'h0, 16'h0);
        check("fir_mul_ovf", overflow, 1'b0);
        issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("fir_mul_r0", outreg_data, 16'h0030);
        read_reg(4'd5, "coeff_r5", 16'h0003);

        // Arithmetic vectors, including overflow boundaries; the write happens regardless.
        foreach (vecs[i]) begin
            load(vecs[i].ra, vecs[i].a);
            load(vecs[i].rb, vecs[i].b);
            issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd, 16'h0, 16'h0);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            if (vecs[i].rd == 4'd0) begin
                issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
                check($sformatf("v%0d_res", i), outreg_data, SAT ? vecs[i].sat : vecs[i].wrap);
            end else begin
                read_reg(vecs[i].rd, $sformatf("v%0d_res", i), SAT ? vecs[i].sat : vecs[i].wrap);
            end
        end

        // Accumulator clear: SUB of a register with itself, even at the most negative value.
        load(4'd0, 16'h5555);
        load(4'd2, 16'h8000);
        issue(SUB, 4'd2, 4'd2, 4'd0, 16'h0, 16'h0);
        check("clr_ovf", overflow, 1'b0);
        issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("clr_r0", outreg_data, 16'h0);

        // Reads in the cycle of a write to the same register see the old value.
        load(4'd3, 16'h4000);
        issue(ADD, 4'd3, 4'd3, 4'd3, 16'h0, 16'h0);
        check("rw_same_ovf", overflow, 1'b1);
        read_reg(4'd3, "rw_same_r3", SAT ? 16'h7FFF : 16'h8000);
        load(4'd3, 16'h0021);
        issue(COPY, 4'd3, 4'd0, 4'd3, 16'h0, 16'h0);
        check("copy_self_ovf", overflow, 1'b0);
        issue(ADD, 4'd3, 4'd3, 4'd0, 16'h0, 16'h0);
        check("copy_self_add_ovf", overflow, 1'b0);
        issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("copy_self_r0", outreg_data, 16'h0042);

        // Reserved opcode and NOP write nothing and never flag overflow.
        load(4'd1, 16'h7FFF);
        load(4'd2, 16'h7FFF);
        issue(RSVD, 4'd1, 4'd2, 4'd0, 16'hFFFF, 16'hFFFF);
        check("rsvd_ovf", overflow, 1'b0);
        issue(NOP, 4'd1, 4'd2, 4'd0, 16'hFFFF, 16'hFFFF);
        check("rsvd_r0", outreg_data, 16'h0042);
        check("nop_ovf", overflow, 1'b0);
        issue(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        check("nop_r0", outreg_data, 16'h0042);
        read_reg(4'd1, "rsvd_r1", 16'h7FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
